// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Desc   : Shared state encoding, owner encoding and default constants for
//          the cpu/dma shared-memory bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int unsigned c_mem_lat_def    = 1;
    localparam int unsigned c_starve_lim_def = 8;

    localparam int unsigned c_addr_w    = 16;
    localparam int unsigned c_data_w    = 8;
    localparam int unsigned c_lat_cnt_w = 4;
    localparam int unsigned c_streak_w  = 8;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter_if
// Desc   : cpu, dma and shared-memory signal bundle; slave = arbiter side,
//          master = requesters plus memory.
// Rev    : 1.0  initial release
// ============================================================================
interface bus_arbiter_if;
    import arb_pkg::*;

    logic                cpu_req;
    logic                cpu_we;
    logic [c_addr_w-1:0] cpu_addr;
    logic [c_data_w-1:0] cpu_wdata;
    logic [c_data_w-1:0] cpu_rdata;
    logic                cpu_ack;

    logic                dma_req;
    logic                dma_we;
    logic [c_addr_w-1:0] dma_addr;
    logic [c_data_w-1:0] dma_wdata;
    logic [c_data_w-1:0] dma_rdata;
    logic                dma_ack;

    logic                mem_en;
    logic                mem_we;
    logic [c_addr_w-1:0] mem_addr;
    logic [c_data_w-1:0] mem_wdata;
    logic [c_data_w-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module : arb_lat_cnt
// Desc   : Memory-latency down-counter; o_done flags the last WAIT cycle.
// Rev    : 1.0  initial release
// ============================================================================
module arb_lat_cnt
    import arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = c_mem_lat_def
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_dec,
    output logic      o_done
);

    localparam logic [c_lat_cnt_w-1:0] c_load_val = c_lat_cnt_w'(MEM_LAT - 1);
    localparam logic [c_lat_cnt_w-1:0] c_one      = c_lat_cnt_w'(1);

    logic [c_lat_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Loaded with MEM_LAT-1, so a count of one marks the final WAIT cycle
    assign o_done = (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter
// Desc   : Two-master (cpu/dma) arbiter for a single shared memory port.
//          Define ARB_STARVE_GUARD_EN to force dma in after STARVE_LIM
//          consecutive contested cpu grants.
// Rev    : 1.0  initial release
// ============================================================================
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = c_mem_lat_def,
    parameter int unsigned STARVE_LIM = c_starve_lim_def
) (
    input  wire logic    ph1,
    input  wire logic    reset,
    bus_arbiter_if.slave bus,
    output logic         owner
);

    localparam bit c_has_wait = (MEM_LAT > 1);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic                r_owner;
    logic                r_we;
    logic [c_addr_w-1:0] r_addr;
    logic [c_data_w-1:0] r_wdata;
    logic [c_data_w-1:0] r_cpu_rdata;
    logic [c_data_w-1:0] r_dma_rdata;

    logic w_any_req;
    logic w_grant;
    logic w_pick_dma;
    logic w_in_access;
    logic w_in_resp;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_done;
    logic w_cpu_rd_ack;
    logic w_dma_rd_ack;

    assign w_any_req   = bus.cpu_req | bus.dma_req;
    assign w_grant     = (r_state == IDLE) & w_any_req;
    assign w_in_access = (r_state == ACCESS);
    assign w_in_resp   = (r_state == RESP);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [c_streak_w-1:0] c_streak_lim = c_streak_w'(STARVE_LIM);
    localparam logic [c_streak_w-1:0] c_streak_one = c_streak_w'(1);

    logic [c_streak_w-1:0] r_cpu_streak;

    assign w_pick_dma = bus.dma_req & (~bus.cpu_req | (r_cpu_streak == c_streak_lim));

    // Only cpu wins that actually kept dma waiting count toward the streak
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_cpu_streak <= '0;
        end else if (w_grant) begin
            if (w_pick_dma) begin
                r_cpu_streak <= '0;
            end else if (bus.dma_req && (r_cpu_streak != c_streak_lim)) begin
                r_cpu_streak <= r_cpu_streak + c_streak_one;
            end
        end
    end
`else
    assign w_pick_dma = bus.dma_req & ~bus.cpu_req;
`endif

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (c_has_wait) begin
                    w_next     = WAIT;
                    w_cnt_load = 1'b1;
                end else begin
                    w_next = RESP;
                end
            end
            WAIT: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_done) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    arb_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (ph1),
        .rst    (reset),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_done (w_cnt_done)
    );

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick_dma ? OWN_DMA : OWN_CPU;
            r_we    <= w_pick_dma ? bus.dma_we    : bus.cpu_we;
            r_addr  <= w_pick_dma ? bus.dma_addr  : bus.cpu_addr;
            r_wdata <= w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
        end
    end

    assign w_cpu_rd_ack = bus.cpu_ack & ~r_we;
    assign w_dma_rd_ack = bus.dma_ack & ~r_we;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_cpu_rd_ack) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            if (w_dma_rd_ack) begin
                r_dma_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = w_in_access;
    assign bus.mem_we    = w_in_access & r_we;
    assign bus.mem_addr  = w_in_access ? r_addr  : '0;
    assign bus.mem_wdata = w_in_access ? r_wdata : '0;

    assign bus.cpu_ack = w_in_resp & (r_owner == OWN_CPU);
    assign bus.dma_ack = w_in_resp & (r_owner == OWN_DMA);

    // Read data is forwarded in the ack cycle itself, then held by the register
    assign bus.cpu_rdata = w_cpu_rd_ack ? bus.mem_rdata : r_cpu_rdata;
    assign bus.dma_rdata = w_dma_rd_ack ? bus.mem_rdata : r_dma_rdata;

    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_arbiter
// Desc   : Directed bench for bus_arbiter: vector table on a MEM_LAT=1 unit
//          plus sequences for starvation, MEM_LAT=3 timing and mid-op reset.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;
    import arb_pkg::*;

    typedef struct packed {
        logic        cpu_req;
        logic        cpu_we;
        logic [15:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [15:0] dma_addr;
        logic [7:0]  dma_wdata;
        logic        exp_owner;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    localparam int N_VEC = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit c_guard      = 1'b1;
    localparam int N_STARVE     = 27;
    localparam int N_STARVE_DMA = 3;
`else
    localparam bit c_guard      = 1'b0;
    localparam int N_STARVE     = 20;
    localparam int N_STARVE_DMA = 0;
`endif

    logic ph1   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic owner_a;
    logic owner_b;
    int   n_vec = 0;
    int   n_bad = 0;

    bus_arbiter_if bus_a ();
    bus_arbiter_if bus_b ();

    bus_arbiter #(.MEM_LAT(1), .STARVE_LIM(8)) u_dut_a (
        .ph1   (ph1),
        .reset (rst_a),
        .bus   (bus_a),
        .owner (owner_a)
    );

    bus_arbiter #(.MEM_LAT(3), .STARVE_LIM(8)) u_dut_b (
        .ph1   (ph1),
        .reset (rst_b),
        .bus   (bus_b),
        .owner (owner_b)
    );

    always #5 ph1 = ~ph1;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hB2;
    endfunction

    // Memory model: read data valid exactly MEM_LAT cycles after mem_en, 0xEE otherwise
    logic [8:0] pipe_a = '0;
    logic [8:0] pb0    = '0;
    logic [8:0] pb1    = '0;
    logic [8:0] pb2    = '0;

    always @(posedge ph1) begin
        pipe_a <= (bus_a.mem_en && !bus_a.mem_we) ? {1'b1, mem_f(bus_a.mem_addr)} : 9'h000;
        pb0    <= (bus_b.mem_en && !bus_b.mem_we) ? {1'b1, mem_f(bus_b.mem_addr)} : 9'h000;
        pb1    <= pb0;
        pb2    <= pb1;
    end

    assign bus_a.mem_rdata = pipe_a[8] ? pipe_a[7:0] : 8'hEE;
    assign bus_b.mem_rdata = pb2[8]    ? pb2[7:0]    : 8'hEE;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ph1);
        @(negedge ph1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t       vecs [N_VEC];
    logic [7:0] exp_cpu_rd;
    logic [7:0] exp_dma_rd;
    logic       exp_dma;
    int         n_cpu_ack;
    int         n_dma_ack;

    initial begin
        //            creq cwe  caddr     cwd     dreq dwe  daddr     dwd     own      we   addr      wd     rdata
        vecs[0] = '{1'b1, 1'b0, 16'h01DD, 8'h33, 1'b0, 1'b0, 16'h0000, 8'h00, OWN_CPU, 1'b0, 16'h01DD, 8'h33, 8'h6E};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0200, 8'hA5, OWN_DMA, 1'b1, 16'h0200, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 16'h1234, 8'h5A, 1'b1, 1'b0, 16'h0300, 8'h11, OWN_CPU, 1'b1, 16'h1234, 8'h5A, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h11, OWN_DMA, 1'b0, 16'h0300, 8'h11, 8'hB1};
        vecs[4] = '{1'b1, 1'b0, 16'hABCD, 8'h77, 1'b1, 1'b1, 16'h4444, 8'h99, OWN_CPU, 1'b0, 16'hABCD, 8'h77, 8'hD4};
        vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'h00, OWN_CPU, 1'b1, 16'hFFFF, 8'hFF, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0000, 8'h00, OWN_DMA, 1'b1, 16'h0000, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h5C, OWN_DMA, 1'b0, 16'h8000, 8'h5C, 8'h32};

        bus_a.cpu_req = 1'b0; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
        bus_a.dma_req = 1'b0; bus_a.dma_we = 1'b0; bus_a.dma_addr = '0; bus_a.dma_wdata = '0;
        bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
        bus_b.dma_req = 1'b0; bus_b.dma_we = 1'b0; bus_b.dma_addr = '0; bus_b.dma_wdata = '0;
        exp_cpu_rd = 8'h00;
        exp_dma_rd = 8'h00;

        // Reset state
        @(negedge ph1);
        check("rst_owner",     16'(owner_a),         16'h0);
        check("rst_cpu_ack",   16'(bus_a.cpu_ack),   16'h0);
        check("rst_dma_ack",   16'(bus_a.dma_ack),   16'h0);
        check("rst_cpu_rdata", 16'(bus_a.cpu_rdata), 16'h0);
        check("rst_dma_rdata", 16'(bus_a.dma_rdata), 16'h0);
        check("rst_mem_en",    16'(bus_a.mem_en),    16'h0);
        check("rst_mem_addr",  bus_a.mem_addr,       16'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Vector table: one full transaction per entry
        for (int i = 0; i < N_VEC; i++) begin
            bus_a.cpu_req = vecs[i].cpu_req; bus_a.cpu_we = vecs[i].cpu_we;
            bus_a.cpu_addr = vecs[i].cpu_addr; bus_a.cpu_wdata = vecs[i].cpu_wdata;
            bus_a.dma_req = vecs[i].dma_req; bus_a.dma_we = vecs[i].dma_we;
            bus_a.dma_addr = vecs[i].dma_addr; bus_a.dma_wdata = vecs[i].dma_wdata;
            cyc();
            check($sformatf("v%0d_acc_owner", i),  16'(owner_a),         16'(vecs[i].exp_owner));
            check($sformatf("v%0d_acc_mem_en", i), 16'(bus_a.mem_en),    16'h1);
            check($sformatf("v%0d_acc_mem_we", i), 16'(bus_a.mem_we),    16'(vecs[i].exp_we));
            check($sformatf("v%0d_acc_addr", i),   bus_a.mem_addr,       vecs[i].exp_addr);
            check($sformatf("v%0d_acc_wdata", i),  16'(bus_a.mem_wdata), 16'(vecs[i].exp_wdata));
            check($sformatf("v%0d_acc_acks", i),   16'({bus_a.cpu_ack, bus_a.dma_ack}), 16'h0);
            cyc();
            if (!vecs[i].exp_we) begin
                if (vecs[i].exp_owner == OWN_CPU) exp_cpu_rd = vecs[i].exp_rdata;
                else                              exp_dma_rd = vecs[i].exp_rdata;
            end
            check($sformatf("v%0d_resp_cpu_ack", i), 16'(bus_a.cpu_ack),   16'(vecs[i].exp_owner == OWN_CPU));
            check($sformatf("v%0d_resp_dma_ack", i), 16'(bus_a.dma_ack),   16'(vecs[i].exp_owner == OWN_DMA));
            check($sformatf("v%0d_resp_cpu_rd", i),  16'(bus_a.cpu_rdata), 16'(exp_cpu_rd));
            check($sformatf("v%0d_resp_dma_rd", i),  16'(bus_a.dma_rdata), 16'(exp_dma_rd));
            check($sformatf("v%0d_resp_mem_en", i),  16'(bus_a.mem_en),    16'h0);
            bus_a.cpu_req = 1'b0;
            bus_a.dma_req = 1'b0;
            cyc();
            check($sformatf("v%0d_idle_acks", i),   16'({bus_a.cpu_ack, bus_a.dma_ack}), 16'h0);
            check($sformatf("v%0d_idle_owner", i),  16'(owner_a),         16'(vecs[i].exp_owner));
            check($sformatf("v%0d_idle_cpu_rd", i), 16'(bus_a.cpu_rdata), 16'(exp_cpu_rd));
            check($sformatf("v%0d_idle_dma_rd", i), 16'(bus_a.dma_rdata), 16'(exp_dma_rd));
        end

        // Both requests held continuously from a fresh reset
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 16'h0040;
        bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dma_addr = 16'h0050;
        n_cpu_ack = 0;
        n_dma_ack = 0;
        for (int t = 0; t < N_STARVE; t++) begin
            exp_dma = c_guard && ((t % 9) == 8);
            cyc();
            check($sformatf("st%0d_acc_acks", t), 16'({bus_a.cpu_ack, bus_a.dma_ack}), 16'h0);
            cyc();
            check($sformatf("st%0d_cpu_ack", t), 16'(bus_a.cpu_ack), 16'(!exp_dma));
            check($sformatf("st%0d_dma_ack", t), 16'(bus_a.dma_ack), 16'(exp_dma));
            if (bus_a.cpu_ack) n_cpu_ack++;
            if (bus_a.dma_ack) n_dma_ack++;
            cyc();
        end
        check("starve_cpu_total", 16'(n_cpu_ack), 16'(N_STARVE - N_STARVE_DMA));
        check("starve_dma_total", 16'(n_dma_ack), 16'(N_STARVE_DMA));

        // Reset asserted during ACCESS on the MEM_LAT=1 unit
        bus_a.dma_req = 1'b0;
        bus_a.cpu_addr = 16'h01DD;
        cyc();
        check("ra_pre_mem_en", 16'(bus_a.mem_en),    16'h1);
        check("ra_pre_cpu_rd", 16'(bus_a.cpu_rdata), 16'hF2);
        rst_a = 1'b1;
        #1;
        check("ra_mem_en",   16'(bus_a.mem_en),    16'h0);
        check("ra_mem_addr", bus_a.mem_addr,       16'h0);
        check("ra_cpu_ack",  16'(bus_a.cpu_ack),   16'h0);
        check("ra_cpu_rd",   16'(bus_a.cpu_rdata), 16'h0);
        check("ra_dma_rd",   16'(bus_a.dma_rdata), 16'h0);
        bus_a.cpu_req = 1'b0;
        cyc();
        rst_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check($sformatf("ra_post%0d_acks", k), 16'({bus_a.cpu_ack, bus_a.dma_ack}), 16'h0);
        end

        // MEM_LAT=3: ack lands four cycles after the grant cycle
        bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 16'h01DD;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("l3_c%0d_cpu_ack", k), 16'(bus_b.cpu_ack), 16'(k == 4));
            check($sformatf("l3_c%0d_mem_en", k),  16'(bus_b.mem_en),  16'(k == 1));
        end
        check("l3_resp_cpu_rd", 16'(bus_b.cpu_rdata), 16'h6E);
        bus_b.cpu_req = 1'b0;
        cyc();
        check("l3_hold_cpu_rd", 16'(bus_b.cpu_rdata), 16'h6E);
        check("l3_idle_ack",    16'(bus_b.cpu_ack),   16'h0);

        // Reset asserted during WAIT while dma owns the bus
        bus_b.dma_req = 1'b1; bus_b.dma_we = 1'b0; bus_b.dma_addr = 16'h0123;
        cyc();
        cyc();
        check("rb_pre_owner",  16'(owner_b),      16'h1);
        check("rb_pre_mem_en", 16'(bus_b.mem_en), 16'h0);
        rst_b = 1'b1;
        #1;
        check("rb_owner",  16'(owner_b),         16'h0);
        check("rb_cpu_rd", 16'(bus_b.cpu_rdata), 16'h0);
        check("rb_acks",   16'({bus_b.cpu_ack, bus_b.dma_ack}), 16'h0);
        check("rb_mem_en", 16'(bus_b.mem_en),    16'h0);
        bus_b.dma_req = 1'b0;
        cyc();
        rst_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check($sformatf("rb_post%0d_acks", k), 16'({bus_b.cpu_ack, bus_b.dma_ack}), 16'h0);
        end
        bus_b.dma_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("rb_new_c%0d_dma_ack", k), 16'(bus_b.dma_ack), 16'(k == 4));
        end
        check("rb_new_dma_rd", 16'(bus_b.dma_rdata), 16'h90);
        bus_b.dma_req = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
